// File: rtl/i2c_sda_ctrl_if.sv
// Command/bus bundle between the I2C master FSM (master side) and the SDA bit engine (slave side).
// The master side also carries the SCL generator phase and the synchronised SDA level.
interface i2c_sda_ctrl_if;
    logic [6:0] phase;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] tx_byte;
    logic       ack_send;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_byte;
    logic       ack_recv;
    logic       done;
    logic       arb_lost;
    logic       busy;

    modport master (
        output phase, cmd_valid, cmd_op, tx_byte, ack_send, sda_in,
        input  cmd_ready, sda_oe, rx_byte, ack_recv, done, arb_lost, busy
    );

    modport slave (
        input  phase, cmd_valid, cmd_op, tx_byte, ack_send, sda_in,
        output cmd_ready, sda_oe, rx_byte, ack_recv, done, arb_lost, busy
    );
endinterface

// File: rtl/i2c_sda_ctrl.sv
// Bit-level SDA engine: runs one START/WRITE/READ/STOP command per request, slot-aligned to the
// SCL generator phase, drives SDA open-drain and flags ACK status and arbitration loss.
module i2c_sda_ctrl #(
    parameter int T_LOW    = 6,
    parameter int T_HIGH   = 4,
    parameter int DATA_LEN = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    i2c_sda_ctrl_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_TX_BIT = 3'd3;
    localparam logic [2:0] ST_TX_ACK = 3'd4;
    localparam logic [2:0] ST_RX_BIT = 3'd5;
    localparam logic [2:0] ST_RX_ACK = 3'd6;
    localparam logic [2:0] ST_STOP   = 3'd7;

    localparam logic [6:0] PH_CHG   = 7'(T_LOW / 2);
    localparam logic [6:0] PH_SMP   = 7'(T_LOW + T_HIGH / 2);
    localparam logic [6:0] PH_END   = 7'(T_LOW + T_HIGH - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_LEN - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] op_q, op_d;
    logic       ack_send_q, ack_send_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       ack_recv_q, ack_recv_d;
    logic       sda_oe_q, sda_oe_d;
    logic       done_q, done_d;
    logic       arb_lost_q, arb_lost_d;

    logic       is_chg_s, is_smp_s, is_end_s;

    function automatic logic [2:0] first_slot(input logic [1:0] op);
        case (op)
            2'b00:   first_slot = ST_START;
            2'b01:   first_slot = ST_TX_BIT;
            2'b10:   first_slot = ST_RX_BIT;
            default: first_slot = ST_STOP;
        endcase
    endfunction

    assign is_chg_s = (bus.phase == PH_CHG);
    assign is_smp_s = (bus.phase == PH_SMP);
    assign is_end_s = (bus.phase == PH_END);

    // Next-state and output-register logic for the command sequencer.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        op_d       = op_q;
        ack_send_d = ack_send_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        ack_recv_d = ack_recv_q;
        sda_oe_d   = sda_oe_q;
        done_d     = 1'b0;
        arb_lost_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d       = bus.cmd_op;
                    tx_shift_d = bus.tx_byte;
                    ack_send_d = bus.ack_send;
                    bit_cnt_d  = BIT_LAST;
                    state_d    = is_end_s ? first_slot(bus.cmd_op) : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (is_end_s) begin
                    state_d = first_slot(op_q);
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_START: begin
                // Release first (allows a repeated START after an ACK), then pull low with SCL high.
                if (is_chg_s) begin
                    sda_oe_d = 1'b0;
                end else if (is_smp_s) begin
                    sda_oe_d = 1'b1;
                end else if (is_end_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_TX_BIT: begin
                if (is_chg_s) begin
                    sda_oe_d = ~tx_shift_q[7];
                end else if (is_smp_s) begin
                    // We released the line but it reads low: another master owns the bus.
                    if (!sda_oe_q && !bus.sda_in) begin
                        arb_lost_d = 1'b1;
                        sda_oe_d   = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end else if (is_end_s) begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0) begin
                        state_d = ST_TX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_TX_ACK: begin
                if (is_chg_s) begin
                    sda_oe_d = 1'b0;
                end else if (is_smp_s) begin
                    ack_recv_d = bus.sda_in;
                end else if (is_end_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_RX_BIT: begin
                if (is_chg_s) begin
                    sda_oe_d = 1'b0;
                end else if (is_smp_s) begin
                    rx_shift_d = {rx_shift_q[6:0], bus.sda_in};
                end else if (is_end_s) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = ST_RX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_RX_ACK: begin
                if (is_chg_s) begin
                    sda_oe_d = ack_send_q;
                end else if (is_smp_s) begin
                    rx_byte_d = rx_shift_q;
                end else if (is_end_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_STOP: begin
                if (is_chg_s) begin
                    sda_oe_d = 1'b1;
                end else if (is_smp_s) begin
                    sda_oe_d = 1'b0;
                end else if (is_end_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset releases SDA at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            op_q       <= 2'b00;
            ack_send_q <= 1'b0;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            ack_recv_q <= 1'b1;
            sda_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            arb_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            op_q       <= op_d;
            ack_send_q <= ack_send_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            ack_recv_q <= ack_recv_d;
            sda_oe_q   <= sda_oe_d;
            done_q     <= done_d;
            arb_lost_q <= arb_lost_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sda_oe    = sda_oe_q;
    assign bus.rx_byte   = rx_byte_q;
    assign bus.ack_recv  = ack_recv_q;
    assign bus.done      = done_q;
    assign bus.arb_lost  = arb_lost_q;

endmodule

// File: tb/tb_i2c_sda_ctrl.sv
// Bench for i2c_sda_ctrl: plays the SCL generator phase and an open-drain SDA line with an external
// device, and checks every cycle against a slot-level model of what each command should do on the wire.
module tb_i2c_sda_ctrl;

    localparam int CHG = 3;
    localparam int SMP = 8;
    localparam int ENDP = 9;
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic clk;
    logic rst_n;
    logic ext_now;
    logic exp_oe;
    logic exp_ack;
    logic [7:0] exp_rx;
    int checks;
    int failures;

    i2c_sda_ctrl_if bus ();

    i2c_sda_ctrl #(.T_LOW(6), .T_HIGH(4), .DATA_LEN(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Open-drain wire: low if we pull or the external device pulls.
    task automatic drive_line();
        bus.sda_in = ~(bus.sda_oe | ext_now);
    endtask

    // One clock: outputs are sampled 1 ns after the edge, then the phase advances.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.phase = (bus.phase == 7'd9) ? 7'd0 : bus.phase + 7'd1;
        drive_line();
    endtask

    // Value SDA enable should take at the change point of slot s of a command.
    function automatic logic chg_oe(input logic [1:0] op, input int s, input logic [7:0] d, input logic a);
        case (op)
            OP_START: return 1'b0;
            OP_WRITE: return (s < 8) ? ~d[7-s] : 1'b0;
            OP_READ:  return (s < 8) ? 1'b0 : a;
            default:  return 1'b1;
        endcase
    endfunction

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            ext_now = 1'b0;
            drive_line();
            tick();
            checks++;
            if (bus.sda_oe !== exp_oe || bus.done !== 1'b0 || bus.arb_lost !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s idle oe/done/arb/ready got=%b%b%b%b exp=%b001", name,
                         bus.sda_oe, bus.done, bus.arb_lost, bus.cmd_ready, exp_oe);
            end
        end
    endtask

    // Issue one command at idle phase acc_ph and check the whole transaction cycle by cycle.
    // ext[s] = external device pulls SDA low during slot s.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic acks,
                           input logic [8:0] ext, input int acc_ph, input bit inject, input string name);
        int nslots;
        int cyc;
        int done_cyc;
        bit arb;
        bit arb_pulse;
        logic [7:0] rx_m;
        nslots = (op == OP_START || op == OP_STOP) ? 1 : 9;
        ext_now = 1'b0;
        drive_line();
        for (int k = 0; k < 12 && bus.phase != 7'(acc_ph); k++) tick();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before_accept got=%b exp=1", name, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.tx_byte   = data;
        bus.ack_send  = acks;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.tx_byte   = 8'($urandom);
        bus.ack_send  = 1'($urandom);
        checks++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after_accept got busy=%b ready=%b exp busy=1 ready=0", name, bus.busy, bus.cmd_ready);
        end
        for (int k = 0; k < 12 && bus.phase != 7'd0; k++) begin
            tick();
            checks++;
            if (bus.sda_oe !== exp_oe || bus.done !== 1'b0 || bus.arb_lost !== 1'b0) begin
                failures++;
                $display("FAIL %s wait_slot oe/done/arb got=%b%b%b exp=%b00", name, bus.sda_oe, bus.done, bus.arb_lost, exp_oe);
            end
        end
        rx_m = 8'h00;
        arb = 1'b0;
        cyc = 0;
        done_cyc = -1;
        for (int s = 0; s < nslots && !arb; s++) begin
            for (int p = 0; p < 10 && !arb; p++) begin
                ext_now = ext[s];
                drive_line();
                if (inject && s == 0 && p == 5) begin
                    bus.cmd_valid = 1'b1;
                    bus.cmd_op    = OP_WRITE;
                    bus.tx_byte   = 8'h00;
                end
                if (inject && p == ENDP) bus.cmd_valid = 1'b0;
                tick();
                arb_pulse = 1'b0;
                if (p == CHG) begin
                    exp_oe = chg_oe(op, s, data, acks);
                end else if (p == SMP) begin
                    if (op == OP_START) exp_oe = 1'b1;
                    else if (op == OP_STOP) exp_oe = 1'b0;
                    else if (op == OP_WRITE && s < 8 && data[7-s] && ext[s]) begin
                        arb_pulse = 1'b1;
                        exp_oe = 1'b0;
                    end else if (op == OP_WRITE && s == 8) exp_ack = ~ext[8];
                    else if (op == OP_READ && s < 8) rx_m[7-s] = ~ext[s];
                    else if (op == OP_READ && s == 8) exp_rx = rx_m;
                end
                checks++;
                if (bus.sda_oe !== exp_oe) begin
                    failures++;
                    $display("FAIL %s sda_oe slot%0d ph%0d got=%b exp=%b", name, s, p, bus.sda_oe, exp_oe);
                end
                checks++;
                if (bus.done !== ((s == nslots - 1) && (p == ENDP))) begin
                    failures++;
                    $display("FAIL %s done slot%0d ph%0d got=%b exp=%b", name, s, p, bus.done, (s == nslots - 1) && (p == ENDP));
                end
                checks++;
                if (bus.arb_lost !== arb_pulse) begin
                    failures++;
                    $display("FAIL %s arb_lost slot%0d ph%0d got=%b exp=%b", name, s, p, bus.arb_lost, arb_pulse);
                end
                checks++;
                if (bus.rx_byte !== exp_rx || bus.ack_recv !== exp_ack) begin
                    failures++;
                    $display("FAIL %s rx/ack slot%0d ph%0d got=%h/%b exp=%h/%b", name, s, p, bus.rx_byte, bus.ack_recv, exp_rx, exp_ack);
                end
                if (bus.done === 1'b1) done_cyc = cyc;
                cyc++;
                arb = arb_pulse;
            end
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_after got=%b exp=1", name, bus.cmd_ready);
        end
        checks++;
        if (done_cyc != (arb ? -1 : nslots * 10 - 1)) begin
            failures++;
            $display("FAIL %s done_latency got=%0d exp=%0d", name, done_cyc, arb ? -1 : nslots * 10 - 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.phase = 7'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.tx_byte = 8'h00;
        bus.ack_send = 1'b0;
        ext_now = 1'b0;
        bus.sda_in = 1'b1;
        exp_oe = 1'b0;
        exp_ack = 1'b1;
        exp_rx = 8'h00;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        checks++;
        if (bus.sda_oe !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.ack_recv !== 1'b1 ||
            bus.rx_byte !== 8'h00 || bus.done !== 1'b0 || bus.arb_lost !== 1'b0) begin
            failures++;
            $display("FAIL reset_values oe=%b ready=%b busy=%b ack=%b rx=%h done=%b arb=%b exp 0 1 0 1 00 0 0",
                     bus.sda_oe, bus.cmd_ready, bus.busy, bus.ack_recv, bus.rx_byte, bus.done, bus.arb_lost);
        end
        idle_cycles(25, "reset_idle");
    endtask

    task automatic test_start();
        run_cmd(OP_START, 8'h00, 1'b0, 9'h000, ENDP, 1'b0, "start");
        idle_cycles(1, "start_after");
    endtask

    task automatic test_write_a5();
        run_cmd(OP_WRITE, 8'hA5, 1'b0, 9'h100, ENDP, 1'b0, "write_a5");
        run_cmd(OP_WRITE, 8'hA5, 1'b0, 9'h100, int'($urandom_range(0, 8)), 1'b0, "write_a5_wait");
    endtask

    task automatic test_arb_loss();
        run_cmd(OP_WRITE, 8'h40, 1'b0, 9'h002, ENDP, 1'b0, "arb_0x40");
        idle_cycles(3, "arb_after");
    endtask

    task automatic test_read_3c();
        logic [7:0] pat;
        logic [8:0] ext;
        pat = 8'h3C;
        ext = 9'h000;
        for (int s = 0; s < 8; s++) ext[s] = ~pat[7-s];
        run_cmd(OP_READ, 8'h00, 1'b0, ext, ENDP, 1'b0, "read_3c");
    endtask

    task automatic test_stop_busy();
        run_cmd(OP_STOP, 8'h00, 1'b0, 9'h000, 2, 1'b1, "stop_busy");
        idle_cycles(15, "stop_ignored");
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [8:0] ext;
        for (int i = 0; i < 14; i++) begin
            op  = 2'($urandom_range(0, 3));
            ext = 9'($urandom);
            if (op == OP_WRITE) ext[7:0] = ext[7:0] & 8'($urandom) & 8'($urandom);
            run_cmd(op, 8'($urandom), 1'($urandom), ext, int'($urandom_range(0, 9)), 1'b0, "random");
            idle_cycles(int'($urandom_range(0, 3)), "random_idle");
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        ext_now = 1'b0;
        for (k = 0; k < 12 && bus.phase != 7'd9; k++) tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_WRITE;
        bus.tx_byte   = 8'h00;
        tick();
        bus.cmd_valid = 1'b0;
        for (k = 0; k < 20 && bus.sda_oe !== 1'b1; k++) tick();
        checks++;
        if (bus.sda_oe !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_write oe_never_driven got=%b exp=1", bus.sda_oe);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sda_oe !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.ack_recv !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_write async oe=%b ready=%b ack=%b done=%b exp 0 1 1 0",
                     bus.sda_oe, bus.cmd_ready, bus.ack_recv, bus.done);
        end
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        exp_oe = 1'b0;
        exp_ack = 1'b1;
        exp_rx = 8'h00;
        checks++;
        if (bus.rx_byte !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_write rx_byte got=%h exp=00", bus.rx_byte);
        end
        idle_cycles(12, "rst_mid_idle");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_start();
        test_write_a5();
        test_arb_loss();
        test_read_3c();
        test_stop_busy();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
